// File: rtl/zld_xc9.sv
// Zero-run-length token decoder: literal tokens emit one word, run tokens emit 1..2^CNTW zeros.
// Optional sticky format-error flag when ZLD_XC9_ERR_EN is defined.
module zld_xc9 #(
    parameter int W    = 16,
    parameter int CNTW = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_v,
    input  logic [W-1:0] i_d,
    output logic         i_b,
    output logic         o_v,
    output logic [W-1:0] o_d,
    input  logic         o_b
`ifdef ZLD_XC9_ERR_EN
    ,
    output logic         err
`endif
);

    // Handshake: a token moves on i_v=1 && i_b=0; a word moves on o_v=1 && o_b=0.
    typedef enum logic [1:0] {
        S_IN  = 2'd0,
        S_LIT = 2'd1,
        S_RUN = 2'd2
    } state_t;

    state_t          state;
    logic [CNTW-1:0] cnt;
    logic [W-1:0]    data_r;

    // Outputs are registered alongside the state so they always mirror it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= S_IN;
            cnt    <= '0;
            data_r <= '0;
            i_b    <= 1'b0;
            o_v    <= 1'b0;
            o_d    <= '0;
        end else begin
            case (state)
                S_IN: begin
                    if (i_v) begin
                        i_b <= 1'b1;
                        o_v <= 1'b1;
                        if (!i_d[W-1]) begin
                            data_r <= {1'b0, i_d[W-2:0]};
                            o_d    <= {1'b0, i_d[W-2:0]};
                            state  <= S_LIT;
                        end else begin
                            cnt   <= i_d[CNTW-1:0];
                            o_d   <= '0;
                            state <= S_RUN;
                        end
                    end
                end
                S_LIT: begin
                    if (!o_b) begin
                        state <= S_IN;
                        i_b   <= 1'b0;
                        o_v   <= 1'b0;
                        o_d   <= '0;
                    end
                end
                S_RUN: begin
                    if (!o_b) begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            state <= S_IN;
                            i_b   <= 1'b0;
                            o_v   <= 1'b0;
                            o_d   <= '0;
                        end
                    end
                end
                default: begin
                    state <= S_IN;
                    i_b   <= 1'b0;
                    o_v   <= 1'b0;
                    o_d   <= '0;
                end
            endcase
        end
    end

`ifdef ZLD_XC9_ERR_EN
    // Zero literals and runs with reserved bits set are malformed; decoding still proceeds.
    logic bad_tok;
    assign bad_tok = i_d[W-1] ? (i_d[W-2:CNTW] != '0) : (i_d[W-2:0] == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (state == S_IN && i_v && bad_tok) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_zld_xc9.sv
// Directed bench for zld_xc9 (W=16, CNTW=4): cycle vector table, stream scoreboard, reset sequences.
module tb_zld_xc9;

    logic        clock;
    logic        reset;
    logic        i_v;
    logic [15:0] i_d;
    logic        i_b;
    logic        o_v;
    logic [15:0] o_d;
    logic        o_b;
`ifdef ZLD_XC9_ERR_EN
    logic        err;
`endif

    zld_xc9 #(.W(16), .CNTW(4)) dut (
        .clock (clock),
        .reset (reset),
        .i_v   (i_v),
        .i_d   (i_d),
        .i_b   (i_b),
        .o_v   (o_v),
        .o_d   (o_d),
        .o_b   (o_b)
`ifdef ZLD_XC9_ERR_EN
        ,
        .err   (err)
`endif
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        iv;
        logic [15:0] id;
        logic        ob;
        logic        eib;
        logic        eov;
        logic [15:0] eod;
        logic        eerr;
        logic        ccnt;
        logic [3:0]  ecnt;
    } vec_t;

    vec_t        vec_q[$];
    logic [15:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic        cur_err  = 1'b0;
    int          vec_no   = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic v(logic iv, logic [15:0] id, logic ob, logic eib, logic eov, logic [15:0] eod);
        vec_t t;
        t = '{iv, id, ob, eib, eov, eod, cur_err, 1'b0, 4'd0};
        vec_q.push_back(t);
    endtask

    task automatic vc(logic ob, logic [3:0] ecnt);
        vec_t t;
        t = '{1'b0, 16'h0, ob, 1'b1, 1'b1, 16'h0, cur_err, 1'b1, ecnt};
        vec_q.push_back(t);
    endtask

    // driver: one vector per cycle, inputs set just after the rising edge, outputs checked on the falling edge
    task automatic run_vecs();
        foreach (vec_q[k]) begin
            i_v = vec_q[k].iv;
            i_d = vec_q[k].id;
            o_b = vec_q[k].ob;
            @(negedge clock);
            check($sformatf("v%0d_i_b", vec_no), 32'(i_b), 32'(vec_q[k].eib));
            check($sformatf("v%0d_o_v", vec_no), 32'(o_v), 32'(vec_q[k].eov));
            check($sformatf("v%0d_o_d", vec_no), 32'(o_d), 32'(vec_q[k].eod));
`ifdef ZLD_XC9_ERR_EN
            check($sformatf("v%0d_err", vec_no), 32'(err), 32'(vec_q[k].eerr));
`endif
            if (vec_q[k].ccnt)
                check($sformatf("v%0d_cnt", vec_no), 32'(dut.cnt), 32'(vec_q[k].ecnt));
            vec_no++;
            @(posedge clock);
            #1;
        end
        vec_q.delete();
    endtask

    task automatic check_idle_outputs(string nm);
        check({nm, "_o_v"}, 32'(o_v), 32'd0);
        check({nm, "_o_d"}, 32'(o_d), 32'd0);
        check({nm, "_i_b"}, 32'(i_b), 32'd0);
`ifdef ZLD_XC9_ERR_EN
        check({nm, "_err"}, 32'(err), 32'd0);
`endif
    endtask

    logic [15:0] toks [3];
    int          idx;

    initial begin
        reset = 1'b0;
        i_v   = 1'b0;
        i_d   = 16'h0;
        o_b   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_idle_outputs("reset");
        reset = 1'b1;
        @(posedge clock);
        #1;

        // literal 0x0005
        v(1, 16'h0005, 0, 0, 0, 16'h0);
        v(0, 16'h0000, 0, 1, 1, 16'h0005);
        v(0, 16'h0000, 0, 0, 0, 16'h0);
        // run 0x800F: 16 zero words
        v(1, 16'h800F, 0, 0, 0, 16'h0);
        for (int i = 0; i < 16; i++) v(0, 16'h0, 0, 1, 1, 16'h0);
        v(0, 16'h0000, 0, 0, 0, 16'h0);
        // run 0x8002 stalled 3 cycles after the first word
        v(1, 16'h8002, 0, 0, 0, 16'h0);
        vc(0, 4'd2);
        vc(1, 4'd1);
        vc(1, 4'd1);
        vc(1, 4'd1);
        vc(0, 4'd1);
        vc(0, 4'd0);
        v(0, 16'h0000, 0, 0, 0, 16'h0);
        // max literal held under back-pressure
        v(1, 16'h7FFF, 0, 0, 0, 16'h0);
        v(0, 16'h0000, 1, 1, 1, 16'h7FFF);
        v(0, 16'h0000, 1, 1, 1, 16'h7FFF);
        v(0, 16'h0000, 0, 1, 1, 16'h7FFF);
        v(0, 16'h0000, 0, 0, 0, 16'h0);
        // shortest run 0x8000
        v(1, 16'h8000, 0, 0, 0, 16'h0);
        v(0, 16'h0000, 0, 1, 1, 16'h0);
        v(0, 16'h0000, 0, 0, 0, 16'h0);
        run_vecs();

        // continuous stream with scoreboard
        toks[0] = 16'h0007;
        toks[1] = 16'h8003;
        toks[2] = 16'h0009;
        exp_q = '{16'h7, 16'h0, 16'h0, 16'h0, 16'h0, 16'h9};
        idx = 0;
        for (int c = 0; c < 40 && (exp_q.size() != 0 || idx < 3); c++) begin
            i_v = (idx < 3);
            i_d = (idx < 3) ? toks[idx] : 16'h0;
            o_b = 1'b0;
            @(negedge clock);
            if (i_v && !i_b) idx++;
            if (o_v && !o_b) begin
                if (exp_q.size() == 0) begin
                    check("stream_extra_word", 32'(o_d), 32'hFFFFFFFF);
                end else begin
                    check("stream_word", 32'(o_d), 32'(exp_q.pop_front()));
                end
            end
            @(posedge clock);
            #1;
        end
        check("stream_left", 32'(exp_q.size()), 32'd0);
        check("stream_tokens", 32'(idx), 32'd3);
        i_v = 1'b0;
        v(0, 16'h0000, 0, 0, 0, 16'h0);
        run_vecs();

        // reset in the third cycle of run 0x800F
        v(1, 16'h800F, 0, 0, 0, 16'h0);
        v(0, 16'h0000, 0, 1, 1, 16'h0);
        v(0, 16'h0000, 0, 1, 1, 16'h0);
        run_vecs();
        check("mid_run_o_v", 32'(o_v), 32'd1);
        reset = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        v(0, 16'h0000, 0, 0, 0, 16'h0);
        v(0, 16'h0000, 0, 0, 0, 16'h0);
        v(1, 16'h0042, 0, 0, 0, 16'h0);
        v(0, 16'h0000, 0, 1, 1, 16'h0042);
        v(0, 16'h0000, 0, 0, 0, 16'h0);
        run_vecs();

        // literal 0x0000 then run 0x8101: three zero words, err sticky when enabled
        v(1, 16'h0000, 0, 0, 0, 16'h0);
`ifdef ZLD_XC9_ERR_EN
        cur_err = 1'b1;
`endif
        v(0, 16'h0000, 0, 1, 1, 16'h0);
        v(1, 16'h8101, 0, 0, 0, 16'h0);
        v(0, 16'h0000, 0, 1, 1, 16'h0);
        v(0, 16'h0000, 0, 1, 1, 16'h0);
        v(0, 16'h0000, 0, 0, 0, 16'h0);
        run_vecs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/zld_xc9.md
ZLD_XC9 -- requirements
Module: zld_xc9

Interface
REQ-001 Parameter W, default 16: data and token width in bits; minimum 8.
REQ-002 Parameter CNTW, default 4: run-length field width in bits; CNTW <= W-2.
REQ-003 The block SHALL provide these ports, one per line:
- clock  input  1  clock; reset is asynchronous, active-low, named reset, and all registers use the rising edge of clock.
- reset  input  1  asynchronous active-low reset.
- i_v  input  1  token valid.
- i_d  input  W  encoded token.
- i_b  output  1  input back-pressure; 1 = token not accepted this cycle.
- o_v  output  1  decoded word valid.
- o_d  output  W  decoded word.
- o_b  input  1  output back-pressure; 1 = word not taken this cycle.
- err  output  1  sticky format error; present only under ZLD_XC9_ERR_EN.

Function
REQ-004 Token format SHALL be: i_d[W-1]=0 is a literal with value {1'b0, i_d[W-2:0]}; i_d[W-1]=1 is a zero run of i_d[CNTW-1:0]+1 words (1..2^CNTW zeros).
REQ-005 The FSM SHALL have 3 states: S_IN, S_LIT, S_RUN, held in a registered state.
REQ-006 In S_IN: i_b=0, o_v=0, o_d=0.
REQ-007 In S_IN with i_v=1, the token SHALL be accepted that cycle.
- literal: data_r <= literal, next state S_LIT.
- run: cnt <= i_d[CNTW-1:0], next state S_RUN.
REQ-008 In S_IN with i_v=0, state, cnt and data_r SHALL hold.
REQ-009 In S_LIT: i_b=1, o_v=1, o_d=data_r. If o_b=0, next state S_IN; else hold.
REQ-010 In S_RUN: i_b=1, o_v=1, o_d=0.
- o_b=0, cnt!=0: cnt <= cnt-1, stay.
- o_b=0, cnt==0: next state S_IN.
- o_b=1: hold state and cnt.
REQ-011 o_v, o_d and i_b SHALL be decoded from registered state and registers only; there SHALL be no combinational path from i_v, i_d or o_b to any output.
REQ-012 Latency: the first decoded word of a token SHALL appear with o_v=1 the cycle after acceptance.
REQ-013 A token SHALL occupy exactly 1 + (words emitted) cycles when o_b=0; no token overlaps another.
REQ-014 While o_v=1 and o_b=1, o_d SHALL stay stable until taken.
REQ-015 An undefined state encoding SHALL return to S_IN on the next clock.
REQ-016 cnt SHALL be CNTW bits wide, decrement only in S_RUN, and never wrap below 0.

Reset
REQ-017 With reset=0, the block SHALL immediately set state=S_IN, cnt=0, data_r=0, err=0, giving o_v=0, o_d=0, i_b=0.
REQ-018 Reset during S_LIT or S_RUN SHALL discard the rest of that token; no further words of it are emitted.
REQ-019 After reset is released, the first token SHALL decode normally.

Configuration
REQ-020 Macro ZLD_XC9_ERR_EN defined: err is a port.
- In S_IN, an accepted literal with i_d[W-2:0]=0 sets err=1.
- In S_IN, an accepted run token with any nonzero bit in i_d[W-2:CNTW] sets err=1.
- err is cleared only by reset.
- Decoding proceeds per REQ-007 regardless of err.
REQ-021 Macro ZLD_XC9_ERR_EN undefined: no err port and no error logic; literal 0 is emitted as 0x0000, and reserved run bits are ignored.

Verification (W=16, CNTW=4)
REQ-022 The bench SHALL cover these directed scenarios:
- Literal 0x0005, o_b=0: o_v=1, o_d=0x0005 for one cycle, starting the cycle after acceptance; i_b=1 only during that cycle.
- Run 0x800F, o_b=0: 16 consecutive cycles of o_v=1, o_d=0x0000; then i_b=0.
- Run 0x8002 with o_b=1 for 3 cycles after the first word: exactly 3 zero words total; o_v stays 1; cnt holds during the stall.
- Stream 0x0007, 0x8003, 0x0009 with i_v=1 continuously: output sequence 7,0,0,0,0,9; tokens accepted only while i_b=0.
- Reset asserted in the 3rd cycle of run 0x800F: o_v=0 at once; after release, token 0x0042 yields the single word 0x0042.
- ZLD_XC9_ERR_EN defined, literal 0x0000 then run 0x8101: err=1 after the first token and still 1 after the second; without the macro, words 0x0000, 0x0000, 0x0000 are emitted.
